// File: rtl/i2c_mon_pkg.sv
// Shared types and constants for the I2C bus monitor.
//   evt_type_e  : event kinds carried in the event FIFO
//   mon_state_e : byte-framing FSM states
//   EVT_W       : packed event record width {type, data, ack, idx, match, rw}
//   pack_evt    : builds a packed event record
package i2c_mon_pkg;

    typedef enum logic [1:0] {
        EVT_START  = 2'd0,
        EVT_RSTART = 2'd1,
        EVT_STOP   = 2'd2,
        EVT_BYTE   = 2'd3
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BITS   = 2'd1,
        ST_ACKBIT = 2'd2
    } mon_state_e;

    localparam int unsigned EVT_W = 17;

    function automatic logic [EVT_W-1:0] pack_evt(
        input evt_type_e  t,
        input logic [7:0] d,
        input logic       a,
        input logic [3:0] i,
        input logic       m,
        input logic       r
    );
        return {t, d, a, i, m, r};
    endfunction

endpackage

// File: rtl/i2c_mon_fifo.sv
// Show-ahead event FIFO for the I2C bus monitor.
// Ports:
//   clk, resetn : system clock, async active-low reset
//   wr_en       : push request; accepted when not full, or when a pop
//                 happens in the same cycle
//   wr_data     : record to push
//   rd_en       : pop request; ignored when empty
//   rd_data     : head record (valid while !empty)
//   full, empty : occupancy flags
module i2c_mon_fifo
    import i2c_mon_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [EVT_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [EVT_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [EVT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full with a simultaneous pop, the write lands in the slot being
    // popped; the head read is combinational so it still sees the old value.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus analyzer. Oversamples SCL/SDA, decodes START, repeated
// START, STOP and 9-bit byte frames, and queues events in a ready/valid FIFO.
// Optional feature macro: I2C_MON_GLITCH_FILTER_EN (per-line glitch filter
// of FILTER_LEN clk cycles).
// Ports:
//   clk, resetn          : system clock (>= 8x SCL), async active-low reset
//   scl, sda             : raw bus lines (asynchronous, never driven)
//   evt_valid/evt_ready  : FIFO head handshake
//   evt_type             : 0=START 1=RSTART 2=STOP 3=BYTE
//   evt_data, evt_ack    : byte value and 9th bit for BYTE events, else 0
//   evt_idx              : byte index in transfer (0 = address), saturating
//   evt_match, evt_rw    : latched address match and R/W of the transfer
//   ovf, ovf_clr         : sticky drop flag and its clear pulse
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int unsigned           NUM_ADDR    = 2,
    parameter logic [NUM_ADDR*7-1:0] MATCH_ADDRS = {7'h25, 7'h50},
    parameter int unsigned           FIFO_DEPTH  = 8,
    parameter int unsigned           FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scl,
    input  logic       sda,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_type,
    output logic [7:0] evt_data,
    output logic       evt_ack,
    output logic [3:0] evt_idx,
    output logic       evt_match,
    output logic       evt_rw,
    output logic       ovf,
    input  logic       ovf_clr
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("FILTER_LEN must be at least 1");
    end

    // ---------------- input path ----------------
    logic [1:0] scl_sync, sda_sync;
    logic       scl_cur, sda_cur;
    logic       scl_prev, sda_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef I2C_MON_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    logic [FCW-1:0] scl_cnt, sda_cnt;
    logic           scl_filt, sda_filt;

    // A line's filtered value follows only after FILTER_LEN consecutive
    // samples disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
        end else begin
            if (scl_sync[1] == scl_filt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FCW'(FILTER_LEN - 1)) begin
                scl_filt <= scl_sync[1];
                scl_cnt  <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[1] == sda_filt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FCW'(FILTER_LEN - 1)) begin
                sda_filt <= sda_sync[1];
                sda_cnt  <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    assign scl_cur = scl_filt;
    assign sda_cur = sda_filt;
`else
    assign scl_cur = scl_sync[1];
    assign sda_cur = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_cur;
            sda_prev <= sda_cur;
        end
    end

    // SDA edges count as conditions only with SCL high on both samples, so a
    // simultaneous SCL/SDA change is never a condition.
    logic start_cond, stop_cond, scl_rise;
    assign start_cond = scl_prev && scl_cur &&  sda_prev && !sda_cur;
    assign stop_cond  = scl_prev && scl_cur && !sda_prev &&  sda_cur;
    assign scl_rise   = !scl_prev && scl_cur;

    // ---------------- framing FSM ----------------
    mon_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             match_q, match_d;
    logic             rw_q, rw_d;
    logic             push_q, push_d;
    logic [EVT_W-1:0] rec_q, rec_d;
    logic             addr_hit;

    always_comb begin
        addr_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_ADDR; i++) begin
            if (MATCH_ADDRS[i*7 +: 7] == shift_q[7:1]) addr_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            idx_q    <= '0;
            match_q  <= 1'b0;
            rw_q     <= 1'b0;
            push_q   <= 1'b0;
            rec_q    <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            idx_q    <= idx_d;
            match_q  <= match_d;
            rw_q     <= rw_d;
            push_q   <= push_d;
            rec_q    <= rec_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        idx_d    = idx_q;
        match_d  = match_q;
        rw_d     = rw_q;
        push_d   = 1'b0;
        rec_d    = '0;

        if (state_q == ST_IDLE) begin
            // Everything but START is ignored while idle.
            if (start_cond) begin
                push_d   = 1'b1;
                rec_d    = pack_evt(EVT_START, 8'h00, 1'b0, 4'd0, match_q, rw_q);
                state_d  = ST_BITS;
                bitcnt_d = '0;
                idx_d    = '0;
            end
        end else if (start_cond) begin
            // Any partially shifted byte is discarded.
            push_d   = 1'b1;
            rec_d    = pack_evt(EVT_RSTART, 8'h00, 1'b0, 4'd0, match_q, rw_q);
            state_d  = ST_BITS;
            bitcnt_d = '0;
            idx_d    = '0;
        end else if (stop_cond) begin
            push_d  = 1'b1;
            rec_d   = pack_evt(EVT_STOP, 8'h00, 1'b0, idx_q, match_q, rw_q);
            state_d = ST_IDLE;
        end else if (scl_rise) begin
            if (state_q == ST_BITS) begin
                shift_d = {shift_q[6:0], sda_cur};
                if (bitcnt_q == 3'd7) begin
                    state_d = ST_ACKBIT;
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end else begin
                // Address byte updates the latched match/rw and reports them.
                if (idx_q == 4'd0) begin
                    match_d = addr_hit;
                    rw_d    = shift_q[0];
                end
                push_d   = 1'b1;
                rec_d    = pack_evt(EVT_BYTE, shift_q, sda_cur, idx_q, match_d, rw_d);
                idx_d    = (idx_q == 4'hF) ? 4'hF : idx_q + 1'b1;
                bitcnt_d = '0;
                state_d  = ST_BITS;
            end
        end
    end

    // ---------------- event FIFO ----------------
    logic [EVT_W-1:0] head;
    logic             fifo_full, fifo_empty;

    i2c_mon_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (push_q),
        .wr_data (rec_q),
        .rd_en   (evt_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A full FIFO is never empty, so a pop that frees a slot is just evt_ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf <= 1'b0;
        end else if (push_q && fifo_full && !evt_ready) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    logic [EVT_W-1:0] head_out;
    assign head_out  = fifo_empty ? '0 : head;
    assign evt_valid = !fifo_empty;
    assign evt_type  = head_out[16:15];
    assign evt_data  = head_out[14:7];
    assign evt_ack   = head_out[6];
    assign evt_idx   = head_out[5:2];
    assign evt_match = head_out[1];
    assign evt_rw    = head_out[0];

endmodule

// File: tb/tb_i2c_bus_monitor.sv
module tb_i2c_bus_monitor;
    import i2c_mon_pkg::*;

    logic       tb_clk = 1'b0;
    logic       resetn;
    logic       scl, sda;
    logic       evt_valid, evt_ready;
    logic [1:0] evt_type;
    logic [7:0] evt_data;
    logic       evt_ack;
    logic [3:0] evt_idx;
    logic       evt_match, evt_rw;
    logic       ovf, ovf_clr;

    int total = 0;
    int bad   = 0;

    always #5 tb_clk = ~tb_clk;

    i2c_bus_monitor #(
        .NUM_ADDR    (2),
        .MATCH_ADDRS ({7'h25, 7'h50}),
        .FIFO_DEPTH  (8),
        .FILTER_LEN  (3)
    ) dut (
        .clk       (tb_clk),
        .resetn    (resetn),
        .scl       (scl),
        .sda       (sda),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_type  (evt_type),
        .evt_data  (evt_data),
        .evt_ack   (evt_ack),
        .evt_idx   (evt_idx),
        .evt_match (evt_match),
        .evt_rw    (evt_rw),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    // Bus driver: SDA changes only while SCL is low, except in START/STOP.
    task automatic bus_start();
        scl = 1'b1; sda = 1'b1; clk_wait(4);
        sda = 1'b0; clk_wait(4);
        scl = 1'b0; clk_wait(4);
    endtask

    task automatic bus_rstart();
        sda = 1'b1; clk_wait(4);
        scl = 1'b1; clk_wait(4);
        sda = 1'b0; clk_wait(4);
        scl = 1'b0; clk_wait(4);
    endtask

    task automatic bus_stop();
        sda = 1'b0; clk_wait(4);
        scl = 1'b1; clk_wait(4);
        sda = 1'b1; clk_wait(4);
    endtask

    task automatic bus_bit(input logic b);
        sda = b;    clk_wait(4);
        scl = 1'b1; clk_wait(4);
        scl = 1'b0; clk_wait(4);
    endtask

    task automatic bus_byte(input logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(d[i]);
        bus_bit(ack);
    endtask

    // Bounded wait for a head event, sampled on the falling edge.
    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge tb_clk);
        while (evt_valid !== 1'b1 && n < 200) begin
            @(negedge tb_clk);
            n++;
        end
        chk({tag, ".valid"}, 32'(evt_valid), 32'd1);
    endtask

    task automatic expect_evt(input string tag, input logic [1:0] t, input logic [7:0] d,
                              input logic a, input logic [3:0] i, input logic chk_idx,
                              input logic m, input logic r);
        wait_valid(tag);
        chk({tag, ".type"},  32'(evt_type),  32'(t));
        chk({tag, ".data"},  32'(evt_data),  32'(d));
        chk({tag, ".ack"},   32'(evt_ack),   32'(a));
        if (chk_idx) chk({tag, ".idx"}, 32'(evt_idx), 32'(i));
        chk({tag, ".match"}, 32'(evt_match), 32'(m));
        chk({tag, ".rw"},    32'(evt_rw),    32'(r));
        evt_ready = 1'b1;
        @(posedge tb_clk);
        #1;
        evt_ready = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        @(negedge tb_clk);
        chk(tag, 32'(evt_valid), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; scl = 1'b1; sda = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
        clk_wait(3);
        @(negedge tb_clk);
        chk("rst.valid", 32'(evt_valid), 32'd0);
        chk("rst.type",  32'(evt_type),  32'd0);
        chk("rst.data",  32'(evt_data),  32'd0);
        chk("rst.idx",   32'(evt_idx),   32'd0);
        chk("rst.flags", 32'({evt_ack, evt_match, evt_rw}), 32'd0);
        chk("rst.ovf",   32'(ovf),       32'd0);
        resetn = 1'b1;
        clk_wait(20);
        expect_empty("idle.no_evt");
        chk("idle.ovf", 32'(ovf), 32'd0);

        // Read from 0x25 with two data bytes.
        bus_start();
        bus_byte(8'h4B, 1'b0);
        bus_byte(8'h18, 1'b0);
        bus_byte(8'h14, 1'b0);
        bus_stop();
        clk_wait(10);
        expect_evt("t1.start", 2'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_evt("t1.addr",  2'd3, 8'h4B, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        expect_evt("t1.b1",    2'd3, 8'h18, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1);
        expect_evt("t1.b2",    2'd3, 8'h14, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1);
        expect_evt("t1.stop",  2'd2, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        expect_empty("t1.drained");

        // Write to unmatched 0x30, NACKed; START reports previous transfer.
        bus_start();
        bus_byte(8'h60, 1'b1);
        bus_stop();
        clk_wait(10);
        expect_evt("t2.start", 2'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        expect_evt("t2.addr",  2'd3, 8'h60, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_evt("t2.stop",  2'd2, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_empty("t2.drained");

        // Repeated START after 3 bits of a data byte; then read from 0x50.
        bus_start();
        bus_byte(8'h4A, 1'b0);
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
        bus_rstart();
        bus_byte(8'hA1, 1'b0);
        bus_stop();
        clk_wait(10);
        expect_evt("t3.start",  2'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_evt("t3.addr",   2'd3, 8'h4A, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        expect_evt("t3.rstart", 2'd1, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        expect_evt("t3.addr2",  2'd3, 8'hA1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        expect_evt("t3.stop",   2'd2, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        expect_empty("t3.drained");

        // Reset mid-transfer clears the queue; rest of the transfer ignored.
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1);
        clk_wait(4);
        resetn = 1'b0;
        clk_wait(2);
        @(negedge tb_clk);
        chk("rst_mid.valid", 32'(evt_valid), 32'd0);
        resetn = 1'b1;
        clk_wait(2);
        bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b0);
        bus_bit(1'b0);
        bus_stop();
        clk_wait(10);
        expect_empty("rst_mid.ignored");

        // Ten events with the consumer stalled: eight kept, overflow flagged.
        bus_start();
        bus_byte(8'h4A, 1'b0);
        for (int i = 1; i <= 7; i++) bus_byte(8'(i * 8'h11), 1'b0);
        bus_stop();
        clk_wait(10);
        chk("ovf.set", 32'(ovf), 32'd1);
        expect_evt("ovf.start", 2'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_evt("ovf.addr",  2'd3, 8'h4A, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++)
            expect_evt($sformatf("ovf.b%0d", i), 2'd3, 8'(i * 8'h11), 1'b0, 4'(i), 1'b1, 1'b1, 1'b0);
        expect_empty("ovf.eight_only");
        chk("ovf.sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        clk_wait(1);
        ovf_clr = 1'b0;
        @(negedge tb_clk);
        chk("ovf.clr", 32'(ovf), 32'd0);

        // Short SDA low pulse while SCL is high.
        scl = 1'b1; sda = 1'b1; clk_wait(6);
        sda = 1'b0; clk_wait(2);
        sda = 1'b1; clk_wait(12);
`ifdef I2C_MON_GLITCH_FILTER_EN
        expect_empty("glitch2.suppressed");
        sda = 1'b0; clk_wait(4);
        sda = 1'b1; clk_wait(12);
        expect_evt("glitch4.start", 2'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        expect_evt("glitch4.stop",  2'd2, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
`else
        expect_evt("glitch2.start", 2'd0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        expect_evt("glitch2.stop",  2'd2, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
`endif
        expect_empty("final.empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
